// File: rtl/sm4_axis_block_gearbox.sv
// sm4_axis_block_gearbox: packs AXI-Stream bytes (MSB lane first) into 128-bit
// SM4 blocks with a one-entry output register.
// Optional macro SM4_PKCS7_PAD_EN: PKCS#7 tail padding, including the extra
// full pad block after a packet that ends exactly on a block boundary.
// Without the macro, partial tail blocks are zero-filled and no pad block exists.
module sm4_axis_block_gearbox #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned USER_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tvalid,
    input  logic                s_axis_tlast,
    input  logic [USER_W-1:0]   s_axis_tuser,
    output logic                s_axis_tready,
    output logic [127:0]        m_axis_tdata,
    output logic [4:0]          m_axis_tcnt,
    output logic                m_axis_tvalid,
    output logic                m_axis_tlast,
    output logic [USER_W-1:0]   m_axis_tuser,
    input  logic                m_axis_tready
);

    localparam int unsigned KeepW = DATA_W / 8;

    typedef enum logic [0:0] {StAccum, StPad} state_e;

    state_e              state_q, state_d;
    logic [127:0]        acc_q, acc_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                in_pkt_q, in_pkt_d;
    logic [USER_W-1:0]   user_q, user_d;

    logic [127:0]        out_data_q, out_data_d;
    logic [4:0]          out_cnt_q, out_cnt_d;
    logic                out_last_q, out_last_d;
    logic [USER_W-1:0]   out_user_q, out_user_d;
    logic                out_valid_q, out_valid_d;

    logic                out_free;
    logic                accept;
    logic [4:0]          beat_bytes;
    logic [4:0]          new_cnt;
    logic [7:0]          fill_byte;
    logic [127:0]        merged;
    logic [127:0]        blk;
    logic [USER_W-1:0]   beat_user;

    // Output register can take a new block this cycle.
    assign out_free      = !out_valid_q || m_axis_tready;
    assign s_axis_tready = !rst && out_free && (state_q == StAccum);
    assign accept        = s_axis_tvalid && s_axis_tready;

    // Bytes contributed by the current beat: full width unless it is the tlast beat.
    always_comb begin
        beat_bytes = 5'(KeepW);
        if (s_axis_tlast) begin
            beat_bytes = '0;
            for (int i = 0; i < int'(KeepW); i++) begin
                beat_bytes = beat_bytes + 5'(s_axis_tkeep[i]);
            end
            // An empty keep on tlast still carries one byte.
            if (beat_bytes == '0) begin
                beat_bytes = 5'd1;
            end
        end
    end

    // Drop the beat's bytes into the accumulator at the current byte offset.
    always_comb begin
        merged = acc_q;
        for (int i = 0; i < int'(KeepW); i++) begin
            if ((int'(cnt_q) + i) < 16 && 5'(i) < beat_bytes) begin
                merged[127 - 8 * (int'(cnt_q) + i) -: 8] = s_axis_tdata[DATA_W - 1 - 8 * i -: 8];
            end
        end
    end

    // Fill the unused tail of a finishing block.
    always_comb begin
        new_cnt = cnt_q + beat_bytes;
`ifdef SM4_PKCS7_PAD_EN
        fill_byte = 8'(5'd16 - new_cnt);
`else
        fill_byte = 8'h00;
`endif
        blk = merged;
        for (int k = 0; k < 16; k++) begin
            if (5'(k) >= new_cnt) begin
                blk[127 - 8 * k -: 8] = fill_byte;
            end
        end
    end

    // Next-state: accumulate beats, emit finished blocks, emit the pad block.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_pkt_d    = in_pkt_q;
        user_d      = user_q;
        out_data_d  = out_data_q;
        out_cnt_d   = out_cnt_q;
        out_last_d  = out_last_q;
        out_user_d  = out_user_q;
        out_valid_d = out_valid_q && !m_axis_tready;
        // Tag is captured from the first beat and held for the rest of the packet.
        beat_user   = in_pkt_q ? user_q : s_axis_tuser;

        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    user_d   = beat_user;
                    in_pkt_d = !s_axis_tlast;
                    if (s_axis_tlast || new_cnt == 5'd16) begin
                        out_valid_d = 1'b1;
                        out_data_d  = blk;
                        out_cnt_d   = new_cnt;
                        out_user_d  = beat_user;
                        out_last_d  = s_axis_tlast;
                        acc_d       = '0;
                        cnt_d       = '0;
`ifdef SM4_PKCS7_PAD_EN
                        // Boundary-aligned end: the pad block carries tlast instead.
                        if (s_axis_tlast && new_cnt == 5'd16) begin
                            out_last_d = 1'b0;
                            state_d    = StPad;
                        end
`endif
                    end else begin
                        acc_d = merged;
                        cnt_d = new_cnt;
                    end
                end
            end
            StPad: begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {16{8'h10}};
                    out_cnt_d   = 5'd0;
                    out_last_d  = 1'b1;
                    out_user_d  = user_q;
                    state_d     = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StAccum;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_pkt_q    <= 1'b0;
            user_q      <= '0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
            out_last_q  <= 1'b0;
            out_user_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_pkt_q    <= in_pkt_d;
            user_q      <= user_d;
            out_data_q  <= out_data_d;
            out_cnt_q   <= out_cnt_d;
            out_last_q  <= out_last_d;
            out_user_q  <= out_user_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tcnt   = out_cnt_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tuser  = out_user_q;
    assign m_axis_tvalid = out_valid_q;

endmodule

// File: tb/tb_sm4_axis_block_gearbox.sv
// Bench for sm4_axis_block_gearbox: a DATA_W=8 instance against a packet-level
// block model with random stimulus, plus a DATA_W=32 instance with literal checks.
`timescale 1ns/1ps
module tb_sm4_axis_block_gearbox;

`ifdef SM4_PKCS7_PAD_EN
    localparam bit PadEn = 1'b1;
`else
    localparam bit PadEn = 1'b0;
`endif

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [127:0] data;
        logic [4:0]   cnt;
        logic         last;
        logic [7:0]   user;
    } blk_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DATA_W = 8 instance
    logic [7:0]   s_tdata = '0;
    logic [0:0]   s_tkeep = '0;
    logic         s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic [7:0]   s_tuser = '0;
    logic [127:0] m_tdata;
    logic [4:0]   m_tcnt;
    logic         m_tvalid, m_tlast;
    logic [7:0]   m_tuser;
    logic         m_tready = 1'b0;

    // DATA_W = 32 instance
    logic [31:0]  w_tdata = '0;
    logic [3:0]   w_tkeep = '0;
    logic         w_tvalid = 1'b0, w_tlast = 1'b0, w_tready;
    logic [7:0]   w_tuser = '0;
    logic [127:0] w_mdata;
    logic [4:0]   w_mcnt;
    logic         w_mvalid, w_mlast;
    logic [7:0]   w_muser;

    sm4_axis_block_gearbox #(.DATA_W(8), .USER_W(8)) dut8 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tcnt(m_tcnt), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready)
    );

    sm4_axis_block_gearbox #(.DATA_W(32), .USER_W(8)) dut32 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(w_tdata), .s_axis_tkeep(w_tkeep), .s_axis_tvalid(w_tvalid),
        .s_axis_tlast(w_tlast), .s_axis_tuser(w_tuser), .s_axis_tready(w_tready),
        .m_axis_tdata(w_mdata), .m_axis_tcnt(w_mcnt), .m_axis_tvalid(w_mvalid),
        .m_axis_tlast(w_mlast), .m_axis_tuser(w_muser), .m_axis_tready(1'b1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_blocks = 0;
    bit hold_en   = 1'b0;
    bit full_rate = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Reference model: split the packet into 16-byte blocks and apply tail rules.
    blk_t exp_q[$];
    blk_t mb_q[$];
    task automatic model_blocks(input byte_q_t b, input logic [7:0] user);
        int   n;
        int   pos;
        int   take;
        blk_t bk;
        n   = b.size();
        pos = 0;
        mb_q.delete();
        while (pos < n) begin
            take = (n - pos >= 16) ? 16 : n - pos;
            bk.data = '0;
            for (int k = 0; k < 16; k++) begin
                if (k < take) bk.data[127 - 8 * k -: 8] = b[pos + k];
                else bk.data[127 - 8 * k -: 8] = PadEn ? 8'(16 - take) : 8'h00;
            end
            bk.cnt  = 5'(take);
            bk.user = user;
            bk.last = (pos + take == n) && !(PadEn && take == 16);
            mb_q.push_back(bk);
            pos += take;
        end
        if (PadEn && (n % 16) == 0) begin
            bk.data = {16{8'h10}};
            bk.cnt  = 5'd0;
            bk.last = 1'b1;
            bk.user = user;
            mb_q.push_back(bk);
        end
    endtask

    // Drive one packet on the 8-bit instance; do_last=0 leaves it unterminated.
    task automatic send_pkt(input byte_q_t b, input logic [7:0] user, input bit do_last,
                            input bit zero_keep);
        int   t;
        logic hs;
        if (do_last) begin
            model_blocks(b, user);
            foreach (mb_q[i]) exp_q.push_back(mb_q[i]);
        end
        for (int i = 0; i < b.size(); i++) begin
            if (!full_rate && $urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = b[i];
            s_tlast  = do_last && (i == b.size() - 1);
            s_tkeep  = (s_tlast && zero_keep) ? 1'b0 : 1'b1;
            s_tuser  = (i == 0) ? user : 8'($urandom);
            hs = 1'b0;
            t  = 0;
            while (!hs && t < 500) begin
                @(negedge clk); hs = s_tready;
                @(posedge clk); #1;
                t++;
            end
            if (!hs) begin
                n_checks++;
                $display("FAIL input_timeout: beat %0d not accepted in 500 cycles, required accept", i);
                s_tvalid = 1'b0;
                return;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic beat32(input logic [31:0] d, input logic [3:0] k, input logic last,
                          input logic [7:0] u);
        int   t;
        logic hs;
        w_tvalid = 1'b1; w_tdata = d; w_tkeep = k; w_tlast = last; w_tuser = u;
        hs = 1'b0;
        t  = 0;
        while (!hs && t < 100) begin
            @(negedge clk); hs = w_tready;
            @(posedge clk); #1;
            t++;
        end
        check("w_beat_accepted", hs, 1'b1);
        w_tvalid = 1'b0;
        w_tlast  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check("drain_all_blocks_out", 128'(exp_q.size()), 128'd0);
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1; s_tvalid = 1'b0; w_tvalid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("s_tready_in_reset", s_tready, 1'b0);
        check("w_tready_in_reset", w_tready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_tdata", m_tdata, 128'd0);
        check("rst_tcnt", m_tcnt, 5'd0);
        check("rst_tlast", m_tlast, 1'b0);
        check("rst_tuser", m_tuser, 8'd0);
        @(posedge clk); #1;
    endtask

    // Downstream ready: random back-pressure unless held low or forced high.
    always @(posedge clk) begin
        #1;
        m_tready = hold_en ? 1'b0 : (full_rate ? 1'b1 : ($urandom_range(0, 3) != 0));
    end

    // Compare process: every handshake against the model, stalls for stability.
    blk_t         e;
    logic         prev_stall = 1'b0;
    logic [127:0] p_data;
    logic [4:0]   p_cnt;
    logic         p_last;
    logic [7:0]   p_user;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", m_tvalid, 1'b1);
                check("hold_data", m_tdata, p_data);
                check("hold_cnt", m_tcnt, p_cnt);
                check("hold_last", m_tlast, p_last);
                check("hold_user", m_tuser, p_user);
            end
            if (m_tvalid && m_tready) begin
                n_blocks++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_block: got %h, required no block", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("blk_data", m_tdata, e.data);
                    check("blk_cnt", m_tcnt, e.cnt);
                    check("blk_last", m_tlast, e.last);
                    check("blk_user", m_tuser, e.user);
                end
            end
            if (m_tvalid && !m_tready) check("s_tready_when_stalled", s_tready, 1'b0);
            prev_stall = m_tvalid && !m_tready;
            p_data = m_tdata; p_cnt = m_tcnt; p_last = m_tlast; p_user = m_tuser;
        end
    end

    byte_q_t b;
    int      nb0;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("init_s_tready_in_reset", s_tready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("init_tvalid", m_tvalid, 1'b0);
        check("init_tdata", m_tdata, 128'd0);
        check("init_tcnt", m_tcnt, 5'd0);
        @(posedge clk); #1;

        // Pin the model with hand-computed blocks, then run the same packets.
        b.delete();
        for (int i = 1; i <= 5; i++) b.push_back(8'(i));
        model_blocks(b, 8'h09);
        check("pin5_nblocks", 128'(mb_q.size()), 128'd1);
        check("pin5_data", mb_q[0].data, PadEn ?
              {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, {11{8'h0B}}} :
              {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 88'h0});
        check("pin5_cnt", mb_q[0].cnt, 5'd5);
        check("pin5_last", mb_q[0].last, 1'b1);
        check("pin5_user", mb_q[0].user, 8'h09);
        send_pkt(b, 8'h09, 1'b1, 1'b0);

        b.delete();
        for (int i = 0; i < 16; i++) b.push_back(8'(i));
        model_blocks(b, 8'h21);
        check("pin16_nblocks", 128'(mb_q.size()), PadEn ? 128'd2 : 128'd1);
        check("pin16_data", mb_q[0].data, 128'h000102030405060708090A0B0C0D0E0F);
        check("pin16_cnt", mb_q[0].cnt, 5'd16);
        check("pin16_last", mb_q[0].last, !PadEn);
        if (PadEn) begin
            check("pin16_pad_data", mb_q[1].data, {16{8'h10}});
            check("pin16_pad_cnt", mb_q[1].cnt, 5'd0);
            check("pin16_pad_last", mb_q[1].last, 1'b1);
        end
        send_pkt(b, 8'h21, 1'b1, 1'b0);

        b.delete();
        b.push_back(8'hA1); b.push_back(8'hA2); b.push_back(8'hA3);
        model_blocks(b, 8'h77);
        check("pin3_data", mb_q[0].data, PadEn ?
              {8'hA1, 8'hA2, 8'hA3, {13{8'h0D}}} : {8'hA1, 8'hA2, 8'hA3, 104'h0});
        drain();

        // Downstream stalled for 10 cycles after the first block of a 20-byte packet.
        b.delete();
        for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
        hold_en = 1'b1;
        fork
            send_pkt(b, 8'h33, 1'b1, 1'b0);
            begin
                int t = 0;
                while (!m_tvalid && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                check("stall_first_block_seen", m_tvalid, 1'b1);
                repeat (10) begin
                    @(negedge clk);
                    check("stall_s_tready_low", s_tready, 1'b0);
                end
                hold_en = 1'b0;
            end
        join
        drain();

        // Reset after 7 bytes of a packet, then a 3-byte packet: one block only.
        full_rate = 1'b1;
        b.delete();
        for (int i = 0; i < 7; i++) b.push_back(8'($urandom));
        send_pkt(b, 8'h44, 1'b0, 1'b0);
        pulse_reset();
        nb0 = n_blocks;
        b.delete();
        b.push_back(8'hA1); b.push_back(8'hA2); b.push_back(8'hA3);
        send_pkt(b, 8'h77, 1'b1, 1'b0);
        drain();
        check("rst_midpkt_one_block", 128'(n_blocks - nb0), 128'd1);

        // Reset while stalled on a boundary-aligned packet (PAD pending when enabled).
        hold_en = 1'b1;
        b.delete();
        for (int i = 0; i < 16; i++) b.push_back(8'($urandom));
        send_pkt(b, 8'h55, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        pulse_reset();
        hold_en = 1'b0;
        nb0 = n_blocks;
        b.delete();
        b.push_back(8'hA1); b.push_back(8'hA2); b.push_back(8'hA3);
        send_pkt(b, 8'h66, 1'b1, 1'b0);
        drain();
        check("rst_midpad_one_block", 128'(n_blocks - nb0), 128'd1);

        // Random packets, back-to-back when full_rate is set.
        for (int p = 0; p < 60; p++) begin
            int len;
            len = (p % 10 == 0) ? 16 * $urandom_range(1, 2) : $urandom_range(1, 40);
            full_rate = ($urandom_range(0, 2) == 0);
            b.delete();
            for (int i = 0; i < len; i++) b.push_back(8'($urandom));
            send_pkt(b, 8'($urandom), 1'b1, $urandom_range(0, 1) == 1);
        end
        drain();

        // 32-bit instance: partial keep on tlast, and empty keep on tlast.
        beat32(32'hAABBCCDD, 4'b1111, 1'b0, 8'h5C);
        beat32(32'h11220000, 4'b1100, 1'b1, 8'hEE);
        @(negedge clk);
        check("w_latency_valid", w_mvalid, 1'b1);
        check("w_tkeep_data", w_mdata, PadEn ?
              {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, {10{8'h0A}}} :
              {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 80'h0});
        check("w_tkeep_cnt", w_mcnt, 5'd6);
        check("w_tkeep_last", w_mlast, 1'b1);
        check("w_tkeep_user", w_muser, 8'h5C);
        @(posedge clk); #1;
        beat32(32'hDEADBEEF, 4'b0000, 1'b1, 8'h3A);
        @(negedge clk);
        check("w_zero_keep_valid", w_mvalid, 1'b1);
        check("w_zero_keep_data", w_mdata, PadEn ? {8'hDE, {15{8'h0F}}} : {8'hDE, 120'h0});
        check("w_zero_keep_cnt", w_mcnt, 5'd1);
        check("w_zero_keep_last", w_mlast, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("w_idle_after_block", w_mvalid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sm4_axis_block_gearbox.md
SM4_AXIS_BLOCK_GEARBOX -- requirements
Module: sm4_axis_block_gearbox

Interface
REQ-001 Parameter DATA_W, default 8, input beat width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter USER_W, default 8, sideband width carried per packet.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_axis_tdata  input  DATA_W  packet bytes; first byte of a beat in the MSB lane.
REQ-006 s_axis_tkeep  input  DATA_W/8  valid lanes, contiguous from MSB lane; honoured only on the tlast beat.
REQ-007 s_axis_tvalid, s_axis_tlast  input  1 each  AXIS beat valid, packet end.
REQ-008 s_axis_tuser  input  USER_W  packet tag, sampled on the first beat of a packet.
REQ-009 s_axis_tready  output  1  beat accepted when tvalid and tready are both high.
REQ-010 m_axis_tdata  output  128  SM4 block, first packet byte in bits [127:120].
REQ-011 m_axis_tcnt  output  5  count of payload bytes in the block, 1..16; 0 for a pure pad block.
REQ-012 m_axis_tvalid, m_axis_tlast  output  1 each  block valid, last block of the packet.
REQ-013 m_axis_tuser  output  USER_W  tag of the packet owning the block.
REQ-014 m_axis_tready  input  1  downstream accepts the block.

Function
REQ-015 Bytes of accepted beats are packed in arrival order into a 128-bit accumulator; a block is complete at 16 bytes.
REQ-016 Non-last beats always contribute DATA_W/8 bytes; DATA_W/8 always divides 16, so no beat straddles two blocks.
REQ-017 The tlast beat contributes popcount(s_axis_tkeep) bytes; an all-zero tkeep on tlast counts as one byte.
REQ-018 States: ACCUM (collecting), PAD (emitting the extra pad block); reset enters ACCUM.
REQ-019 A completed block is loaded into the output register on the clock edge that accepts its final byte; m_axis_tvalid rises in the next cycle (latency 1).
REQ-020 The output register holds data, tcnt, tlast and tuser stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-021 s_axis_tready = !(m_axis_tvalid && !m_axis_tready) && state==ACCUM; a full output register accepted in the same cycle a new block completes is overwritten without a bubble.
REQ-022 m_axis_tuser for every block of a packet equals s_axis_tuser sampled on that packet's first beat; the tag is held even if the input changes mid-packet.
REQ-023 m_axis_tlast is set only on the final block of a packet; a new packet never shares a block with the previous packet.
REQ-024 Packet of 0 beats is impossible; back-to-back packets with no idle cycle are supported at full throughput.

Reset
REQ-025 When rst=1 at an edge: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tcnt=0, m_axis_tuser=0, accumulator and byte count cleared, state ACCUM.
REQ-026 s_axis_tready=0 during any cycle in which rst=1.
REQ-027 Reset mid-packet or mid-PAD discards all partial and pending data; the first beat after reset starts a new packet.

Configuration
REQ-028 Macro SM4_PKCS7_PAD_EN selects tail handling.
REQ-029 Defined: a partial last block of n bytes is filled with 16-n bytes of value 16-n, tcnt=n; if the packet ends exactly on a block boundary, that block has tlast=0 and the FSM enters PAD, emitting one block of sixteen 0x10 bytes, tcnt=0, tlast=1, then returns to ACCUM.
REQ-030 Not defined: a partial last block is zero-filled with tcnt=n and tlast=1; an exact-multiple packet ends on its last full block with tlast=1; the PAD state is never entered.

Verification
REQ-031 DATA_W=8, macro on, 5 bytes 01..05, tuser=0x09 -> one block 0102030405 followed by 0B repeated 11, tcnt=5, tlast=1, tuser=0x09.
REQ-032 DATA_W=8, macro on, 16 bytes 00..0F -> block 000102..0F with tlast=0, tcnt=16, then block of 0x10 bytes with tcnt=0, tlast=1.
REQ-033 Same 16 bytes, macro off -> single block 000102..0F with tcnt=16, tlast=1; no second block.
REQ-034 DATA_W=32, macro off, beats 0xAABBCCDD then tlast beat 0x11220000 with tkeep=4'b1100 -> block AABBCCDD1122 followed by 20 zero nibbles, tcnt=6, tlast=1.
REQ-035 DATA_W=8, 20-byte packet with m_axis_tready held 0 for 10 cycles after the first block -> first block stable throughout, s_axis_tready=0 once a second block would complete, no byte lost or duplicated.
REQ-036 rst pulsed for one cycle after 7 bytes of a packet, then a 3-byte packet 0xA1A2A3 -> only one block is output, A1A2A3 followed by 0D repeated 13 with the macro on.
